decode_pipe: RTL and testbench

Parametrised successor to the single-issue instruction decode stage. It decodes RV32 R-type and I-type ALU instructions into register-file read addresses, an ALU operation code, an immediate and a write-back destination. Each output group is re-timed to its own configurable pipeline depth, and the whole pipeline honours a global stall. It sits between instruction fetch and the register file / ALU / write-back stages of the core.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/delay_line.sv | 36 +++
 rtl/decode_pipe.sv | 189 ++++++++++++++++++
 tb/tb_decode_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Package  : decode_pkg
// Purpose  : Opcode/funct constants, ALU codes and stage payloads for decode_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam logic [6:0] c_opc_r  = 7'b0110011;
    localparam logic [6:0] c_opc_i  = 7'b0010011;
    localparam logic [6:0] c_opc_s  = 7'b0100011;
    localparam logic [6:0] c_opc_sb = 7'b1100011;
    localparam logic [6:0] c_opc_uj = 7'b1101111;

    localparam logic [6:0] c_f7_zero = 7'h00;
    localparam logic [6:0] c_f7_alt  = 7'h20;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } alu_grp_t;

    localparam int c_alu_grp_w = $bits(alu_grp_t);

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module   : delay_line
// Purpose  : Enabled shift register of DEPTH stages with asynchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe
// Purpose  : RV32 R/I ALU decode with per-group latency re-timing and global stall.
// Revision : 1.0 - initial release
// ============================================================================
module decode_pipe #(
    parameter int ALU_LAT = 2,
    parameter int WB_LAT  = 3,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic [31:0]       inst_i,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic              read_en_o,
    output logic [3:0]        alu_code_o,
    output logic [31:0]       imm_o,
    output logic              use_imm_o,
    output logic              illegal_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              wb_en_o
);

    import decode_pkg::*;

    localparam int c_wb_w = REG_AW + 1;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_shamt;
    logic        w_legal;
    logic        w_itype;
    logic        w_en;

    logic [REG_AW-1:0] rs1_d, rs1_q;
    logic [REG_AW-1:0] rs2_d, rs2_q;
    logic              read_en_d, read_en_q;
    alu_grp_t          alu_d, alu_s1_q;
    logic [REG_AW-1:0] rd_d;
    logic              wb_en_d;
    logic [c_wb_w-1:0] wb_s1_q;

    alu_grp_t          w_alu_out;
    logic [c_wb_w-1:0] w_wb_out;

    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];
    assign w_shamt  = {27'd0, inst_i[24:20]};
    assign w_en     = ~stall_i;

    // A bubble leaves every field at zero, so it can never raise illegal.
    always_comb begin
        rs1_d     = '0;
        rs2_d     = '0;
        read_en_d = 1'b0;
        alu_d     = '0;
        rd_d      = '0;
        wb_en_d   = 1'b0;
        w_legal   = 1'b0;
        w_itype   = 1'b0;
        if (start_i) begin
            read_en_d  = 1'b1;
            rs1_d[4:0] = inst_i[19:15];
            rs2_d[4:0] = inst_i[24:20];
            case (w_opcode)
                c_opc_r: begin
                    w_legal = 1'b1;
                    case ({w_funct7, w_funct3})
                        {c_f7_zero, 3'd0}: alu_d.code = ALU_ADD;
                        {c_f7_alt,  3'd0}: alu_d.code = ALU_SUB;
                        {c_f7_zero, 3'd7}: alu_d.code = ALU_AND;
                        {c_f7_zero, 3'd6}: alu_d.code = ALU_OR;
                        {c_f7_zero, 3'd4}: alu_d.code = ALU_XOR;
                        {c_f7_zero, 3'd1}: alu_d.code = ALU_SLL;
                        {c_f7_zero, 3'd5}: alu_d.code = ALU_SRL;
                        {c_f7_alt,  3'd5}: alu_d.code = ALU_SRA;
                        default:           w_legal    = 1'b0;
                    endcase
                end
                c_opc_i: begin
                    w_legal   = 1'b1;
                    w_itype   = 1'b1;
                    alu_d.imm = sext12(inst_i[31:20]);
                    case (w_funct3)
                        3'd0: alu_d.code = ALU_ADD;
                        3'd7: alu_d.code = ALU_AND;
                        3'd6: alu_d.code = ALU_OR;
                        3'd4: alu_d.code = ALU_XOR;
                        3'd1: begin
                            alu_d.imm = w_shamt;
                            if (w_funct7 == c_f7_zero) alu_d.code = ALU_SLL;
                            else                       w_legal    = 1'b0;
                        end
                        3'd5: begin
                            alu_d.imm = w_shamt;
                            if (w_funct7 == c_f7_zero)     alu_d.code = ALU_SRL;
                            else if (w_funct7 == c_f7_alt) alu_d.code = ALU_SRA;
                            else                           w_legal    = 1'b0;
                        end
                        default: w_legal = 1'b0;
                    endcase
                end
                // Store, branch and jump formats are not ALU operations here.
                c_opc_s, c_opc_sb, c_opc_uj: w_legal = 1'b0;
                default:                     w_legal = 1'b0;
            endcase

            if (w_legal) begin
                alu_d.use_imm = w_itype;
                if (w_itype) rs2_d = '0;
                if (inst_i[11:7] != 5'd0) begin
                    wb_en_d   = 1'b1;
                    rd_d[4:0] = inst_i[11:7];
                end
            end else begin
                alu_d         = '0;
                alu_d.illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            read_en_q <= 1'b0;
            alu_s1_q  <= '0;
            wb_s1_q   <= '0;
        end else if (w_en) begin
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            read_en_q <= read_en_d;
            alu_s1_q  <= alu_d;
            wb_s1_q   <= {rd_d, wb_en_d};
        end
    end

    generate
        if (ALU_LAT > 1) begin : g_alu_dly
            logic [c_alu_grp_w-1:0] w_q;
            delay_line #(
                .WIDTH (c_alu_grp_w),
                .DEPTH (ALU_LAT - 1)
            ) u_alu_dly (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (w_en),
                .d_i   (alu_s1_q),
                .q_o   (w_q)
            );
            assign w_alu_out = alu_grp_t'(w_q);
        end else begin : g_alu_direct
            assign w_alu_out = alu_s1_q;
        end

        if (WB_LAT > 1) begin : g_wb_dly
            delay_line #(
                .WIDTH (c_wb_w),
                .DEPTH (WB_LAT - 1)
            ) u_wb_dly (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (w_en),
                .d_i   (wb_s1_q),
                .q_o   (w_wb_out)
            );
        end else begin : g_wb_direct
            assign w_wb_out = wb_s1_q;
        end
    endgenerate

    assign rs1_o      = rs1_q;
    assign rs2_o      = rs2_q;
    assign read_en_o  = read_en_q;
    assign alu_code_o = w_alu_out.code;
    assign imm_o      = w_alu_out.imm;
    assign use_imm_o  = w_alu_out.use_imm;
    assign illegal_o  = w_alu_out.illegal;
    assign rd_o       = w_wb_out[c_wb_w-1:1];
    assign wb_en_o    = w_wb_out[0];

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_pipe
// Purpose  : Scoreboard bench for decode_pipe at default and (1,8) latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        read_en;
        logic [3:0]  code;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
        logic [4:0]  rd;
        logic        wb_en;
    } exp_t;

    localparam int NVEC = 17;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] inst  = 32'd0;
    exp_t        cur_exp = '0;

    logic [31:0] tv_inst [NVEC];
    exp_t        tv_exp  [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic check(input int cfg, input string nm,
                         input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %h, expected %h (t=%0t)", cfg, nm, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [3:0] code, input logic [31:0] imm,
                                input logic ui, input logic ill,
                                input logic [4:0] rd, input logic wb);
        exp_t e;
        e = '{rs1, rs2, 1'b1, code, imm, ui, ill, rd, wb};
        return e;
    endfunction

    // Config 0: defaults (2,3). Config 1: ALU_LAT=1, WB_LAT=8.
    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int ALU_L = (k == 0) ? 2 : 1;
        localparam int WB_L  = (k == 0) ? 3 : 8;

        logic [4:0]  rs1, rs2, rd;
        logic        read_en, use_imm, illegal, wb_en;
        logic [3:0]  alu_code;
        logic [31:0] imm;

        exp_t q_rs[$];
        exp_t q_alu[$];
        exp_t q_wb[$];
        exp_t e_rs  = '0;
        exp_t e_alu = '0;
        exp_t e_wb  = '0;
        logic [7:0] v   = '0;
        logic       adv = 1'b0;

        decode_pipe #(
            .ALU_LAT (ALU_L),
            .WB_LAT  (WB_L),
            .REG_AW  (5)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_i    (start),
            .stall_i    (stall),
            .inst_i     (inst),
            .rs1_o      (rs1),
            .rs2_o      (rs2),
            .read_en_o  (read_en),
            .alu_code_o (alu_code),
            .imm_o      (imm),
            .use_imm_o  (use_imm),
            .illegal_o  (illegal),
            .rd_o       (rd),
            .wb_en_o    (wb_en)
        );

        // Accepted instructions are queued; v tracks where each one sits.
        always @(posedge clk) begin
            adv <= rst_n && !stall;
            if (!rst_n) begin
                v <= '0;
            end else if (!stall) begin
                v <= {v[6:0], start};
                if (start) begin
                    q_rs.push_back(cur_exp);
                    q_alu.push_back(cur_exp);
                    q_wb.push_back(cur_exp);
                end
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                q_rs.delete();
                q_alu.delete();
                q_wb.delete();
                e_rs  = '0;
                e_alu = '0;
                e_wb  = '0;
            end else if (adv) begin
                e_rs  = '0;
                e_alu = '0;
                e_wb  = '0;
                if (v[0]) begin
                    if (q_rs.size() != 0) e_rs = q_rs.pop_front();
                    else begin n_cmp++; n_bad++; $display("FAIL cfg%0d rs_queue: got output slot, expected a queued entry", k); end
                end
                if (v[ALU_L-1]) begin
                    if (q_alu.size() != 0) e_alu = q_alu.pop_front();
                    else begin n_cmp++; n_bad++; $display("FAIL cfg%0d alu_queue: got output slot, expected a queued entry", k); end
                end
                if (v[WB_L-1]) begin
                    if (q_wb.size() != 0) e_wb = q_wb.pop_front();
                    else begin n_cmp++; n_bad++; $display("FAIL cfg%0d wb_queue: got output slot, expected a queued entry", k); end
                end
            end
            check(k, "rs_group",  64'({rs1, rs2, read_en}), 64'({e_rs.rs1, e_rs.rs2, e_rs.read_en}));
            check(k, "alu_group", 64'({alu_code, imm, use_imm, illegal}),
                  64'({e_alu.code, e_alu.imm, e_alu.use_imm, e_alu.illegal}));
            check(k, "wb_group",  64'({rd, wb_en}), 64'({e_wb.rd, e_wb.wb_en}));
        end
    end

    task automatic issue(input int i);
        @(posedge clk); #2;
        stall   = 1'b0;
        start   = 1'b1;
        inst    = tv_inst[i];
        cur_exp = tv_exp[i];
    endtask

    task automatic bubbles(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            stall   = 1'b0;
            start   = 1'b0;
            inst    = $urandom;
            cur_exp = '0;
        end
    endtask

    task automatic stall_for(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            stall = 1'b1;
            start = 1'b1;
            inst  = $urandom;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2;
        rst_n = 1'b0;
        start = 1'b1;
        inst  = $urandom;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        tv_inst[0]  = 32'h002081B3; tv_exp[0]  = mk(5'd1,  5'd2,  4'd1, 32'h0,        1'b0, 1'b0, 5'd3,  1'b1);
        tv_inst[1]  = 32'h407302B3; tv_exp[1]  = mk(5'd6,  5'd7,  4'd2, 32'h0,        1'b0, 1'b0, 5'd5,  1'b1);
        tv_inst[2]  = 32'hFFF00213; tv_exp[2]  = mk(5'd0,  5'd0,  4'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd4,  1'b1);
        tv_inst[3]  = 32'h40335313; tv_exp[3]  = mk(5'd6,  5'd0,  4'd8, 32'h3,        1'b1, 1'b0, 5'd6,  1'b1);
        tv_inst[4]  = 32'h00000033; tv_exp[4]  = mk(5'd0,  5'd0,  4'd1, 32'h0,        1'b0, 1'b0, 5'd0,  1'b0);
        tv_inst[5]  = 32'h0000007F; tv_exp[5]  = mk(5'd0,  5'd0,  4'd0, 32'h0,        1'b0, 1'b1, 5'd0,  1'b0);
        tv_inst[6]  = 32'h00C5F533; tv_exp[6]  = mk(5'd11, 5'd12, 4'd3, 32'h0,        1'b0, 1'b0, 5'd10, 1'b1);
        tv_inst[7]  = 32'h08044393; tv_exp[7]  = mk(5'd8,  5'd0,  4'd5, 32'h80,       1'b1, 1'b0, 5'd7,  1'b1);
        tv_inst[8]  = 32'h40111193; tv_exp[8]  = mk(5'd2,  5'd1,  4'd0, 32'h0,        1'b0, 1'b1, 5'd0,  1'b0);
        tv_inst[9]  = 32'h4020D4B3; tv_exp[9]  = mk(5'd1,  5'd2,  4'd8, 32'h0,        1'b0, 1'b0, 5'd9,  1'b1);
        tv_inst[10] = 32'h003160B3; tv_exp[10] = mk(5'd2,  5'd3,  4'd4, 32'h0,        1'b0, 1'b0, 5'd1,  1'b1);
        tv_inst[11] = 32'h01F15113; tv_exp[11] = mk(5'd2,  5'd0,  4'd7, 32'd31,       1'b1, 1'b0, 5'd2,  1'b1);
        tv_inst[12] = 32'h005211B3; tv_exp[12] = mk(5'd4,  5'd5,  4'd6, 32'h0,        1'b0, 1'b0, 5'd3,  1'b1);
        tv_inst[13] = 32'h0020A1B3; tv_exp[13] = mk(5'd1,  5'd2,  4'd0, 32'h0,        1'b0, 1'b1, 5'd0,  1'b0);
        tv_inst[14] = 32'h80037293; tv_exp[14] = mk(5'd6,  5'd0,  4'd3, 32'hFFFFF800, 1'b1, 1'b0, 5'd5,  1'b1);
        tv_inst[15] = 32'h022081B3; tv_exp[15] = mk(5'd1,  5'd2,  4'd0, 32'h0,        1'b0, 1'b1, 5'd0,  1'b0);
        tv_inst[16] = 32'h00509093; tv_exp[16] = mk(5'd1,  5'd0,  4'd6, 32'd5,        1'b1, 1'b0, 5'd1,  1'b1);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        issue(0);  bubbles(10);
        issue(1);  issue(2);  bubbles(10);
        issue(3);  bubbles(10);
        issue(4);  issue(5);  bubbles(10);
        for (int i = 6; i < NVEC; i++) issue(i);
        bubbles(10);

        issue(9);  issue(10); issue(11);
        stall_for(4);
        bubbles(10);

        issue(12); stall_for(2); issue(13); bubbles(10);

        for (int i = 0; i < 6; i++) issue(i);
        reset_pulse();
        bubbles(12);

        issue(14); issue(0); bubbles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
